// File: rtl/regfile_scoreboard.sv
`timescale 1ns/1ps
// Integer register file with optional write-to-read bypass and per-register pending-write scoreboard.
// Reads are combinational (zero latency); writes, scoreboard, pending_cnt and wb_spurious update at the edge.
// No backpressure: every strobe is accepted each cycle; decode stalls itself off rd_busy.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   rd_addr/rd_data   NRD packed read ports (port k at [k*AW +: AW] / [k*XLEN +: XLEN])
//   rd_busy           per-port: addressed register has an outstanding producer
//   wr_en/addr/data   writeback; clears the pending bit of wr_addr
//   iss_en/iss_addr   issue mark; sets the pending bit of iss_addr
//   flush             squash: clears every pending bit, drops a same-cycle issue
//   pending_cnt       registered popcount of the pending bits
//   wb_spurious       one-cycle pulse after a writeback to a non-pending register
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [AW:0]         pending_cnt,
  output logic                wb_spurious
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;
  logic [AW:0]      cnt_next;
  logic             wr_live;
  logic             iss_live;

  // x0 is never a real destination, so strobes aimed at it are ignored everywhere.
  assign wr_live  = wr_en  && (wr_addr  != '0);
  assign iss_live = iss_en && (iss_addr != '0);

  // Read ports: x0 forced to zero, then bypass, then array/scoreboard lookup.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[k*AW +: AW];
    assign hit  = (BYPASS != 0) && wr_live && (wr_addr == addr);

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
      end else if (hit) begin
        // The producer is completing this cycle, so the operand is ready now.
        data = wr_data;
        busy = 1'b0;
      end else begin
        data = regs[addr];
        busy = pending[addr];
      end
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = busy;
  end

  // Scoreboard next state. Set is applied after clear so a same-cycle issue
  // to the register being written back keeps it pending (newer producer).
  always_comb begin
    pending_next = pending;
    if (flush) begin
      pending_next = '0;
    end else begin
      if (wr_live)  pending_next[wr_addr]  = 1'b0;
      if (iss_live) pending_next[iss_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + (AW+1)'(pending_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      pending_cnt <= '0;
      wb_spurious <= 1'b0;
    end else begin
      pending     <= pending_next;
      pending_cnt <= cnt_next;
      // Judged against the pre-edge bit: a same-cycle issue does not excuse it.
      wb_spurious <= wr_live && !pending[wr_addr];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
`timescale 1ns/1ps
// Self-checking bench for regfile_scoreboard: one bypassing and one non-bypassing
// instance share all inputs. Expected values are pushed into queues as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [AW:0]         pending_cnt, pending_cnt_nb;
  logic                wb_spurious, wb_spurious_nb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] exp_data_q [$];
  logic [1:0]      exp_busy_q [$];
  logic [AW:0]     exp_cnt_q  [$];
  logic            exp_spur_q [$];

  logic [XLEN-1:0] ed;
  logic [1:0]      eb;
  logic [AW:0]     ec;
  logic            es;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .pending_cnt(pending_cnt), .wb_spurious(wb_spurious)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .pending_cnt(pending_cnt_nb), .wb_spurious(wb_spurious_nb)
  );

  // Inputs change 1 ns after a rising edge; outputs are sampled 1-2 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); set_rd(0, 0);
    tick(); tick();
    rst = 1'b0;
    exp_cnt_q.push_back('0); exp_spur_q.push_back(1'b0);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL reset_cnt: got %0d, expected %0d", pending_cnt, ec); end
    es = exp_spur_q.pop_front(); n_checks++;
    if (wb_spurious !== es) begin n_fail++; $display("FAIL reset_spur: got %b, expected %b", wb_spurious, es); end
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      #1;
      exp_data_q.push_back('0); exp_data_q.push_back('0); exp_busy_q.push_back(2'b00);
      ed = exp_data_q.pop_front(); n_checks++;
      if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL reset_rd0[%0d]: got %h, expected %h", a, rd_data[31:0], ed); end
      ed = exp_data_q.pop_front(); n_checks++;
      if (rd_data[63:32] !== ed) begin n_fail++; $display("FAIL reset_rd1[%0d]: got %h, expected %h", 31 - a, rd_data[63:32], ed); end
      eb = exp_busy_q.pop_front(); n_checks++;
      if (rd_busy !== eb) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b, expected %b", a, rd_busy, eb); end
    end
  endtask

  // Issue x5, then write it back while both ports read x5. Also covers the
  // non-bypass instance, which must show old data and busy in that cycle.
  task automatic test_bypass();
    idle(); iss_en = 1'b1; iss_addr = 5'd5; set_rd(5, 5);
    tick();
    exp_cnt_q.push_back(6'd1); exp_busy_q.push_back(2'b11);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL byp_cnt_iss: got %0d, expected %0d", pending_cnt, ec); end
    idle(); #1;
    eb = exp_busy_q.pop_front(); n_checks++;
    if (rd_busy !== eb) begin n_fail++; $display("FAIL byp_busy_pending: got %b, expected %b", rd_busy, eb); end

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    #1;
    exp_data_q.push_back(32'hDEADBEEF); exp_data_q.push_back(32'hDEADBEEF); exp_busy_q.push_back(2'b00);
    exp_data_q.push_back(32'h0); exp_busy_q.push_back(2'b11);
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL byp_rd0: got %h, expected %h", rd_data[31:0], ed); end
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[63:32] !== ed) begin n_fail++; $display("FAIL byp_rd1: got %h, expected %h", rd_data[63:32], ed); end
    eb = exp_busy_q.pop_front(); n_checks++;
    if (rd_busy !== eb) begin n_fail++; $display("FAIL byp_busy: got %b, expected %b", rd_busy, eb); end
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data_nb[31:0] !== ed) begin n_fail++; $display("FAIL nobyp_rd0: got %h, expected %h", rd_data_nb[31:0], ed); end
    eb = exp_busy_q.pop_front(); n_checks++;
    if (rd_busy_nb !== eb) begin n_fail++; $display("FAIL nobyp_busy: got %b, expected %b", rd_busy_nb, eb); end

    tick();
    idle();
    exp_cnt_q.push_back(6'd0); exp_spur_q.push_back(1'b0); exp_data_q.push_back(32'hDEADBEEF);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL byp_cnt_wb: got %0d, expected %0d", pending_cnt, ec); end
    es = exp_spur_q.pop_front(); n_checks++;
    if (wb_spurious !== es) begin n_fail++; $display("FAIL byp_spur: got %b, expected %b", wb_spurious, es); end
    #1;
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data_nb[31:0] !== ed) begin n_fail++; $display("FAIL nobyp_after: got %h, expected %h", rd_data_nb[31:0], ed); end
  endtask

  task automatic test_x0();
    idle(); iss_en = 1'b1; iss_addr = 5'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    set_rd(0, 0);
    #1;
    exp_data_q.push_back('0); exp_busy_q.push_back(2'b00);
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL x0_rd_wr: got %h, expected %h", rd_data[31:0], ed); end
    eb = exp_busy_q.pop_front(); n_checks++;
    if (rd_busy !== eb) begin n_fail++; $display("FAIL x0_busy: got %b, expected %b", rd_busy, eb); end
    tick();
    idle();
    exp_cnt_q.push_back(6'd0); exp_spur_q.push_back(1'b0); exp_data_q.push_back('0);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL x0_cnt: got %0d, expected %0d", pending_cnt, ec); end
    es = exp_spur_q.pop_front(); n_checks++;
    if (wb_spurious !== es) begin n_fail++; $display("FAIL x0_spur: got %b, expected %b", wb_spurious, es); end
    #1;
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL x0_rd_after: got %h, expected %h", rd_data[31:0], ed); end
  endtask

  // Issue and writeback to x7 in one cycle: data lands, pending stays set,
  // and the writeback is still spurious (x7 was not pending before the edge).
  task automatic test_set_wins();
    idle(); iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    set_rd(7, 0);
    tick();
    idle();
    exp_cnt_q.push_back(6'd1); exp_spur_q.push_back(1'b1);
    exp_data_q.push_back(32'h55); exp_busy_q.push_back(2'b01);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL sw_cnt: got %0d, expected %0d", pending_cnt, ec); end
    es = exp_spur_q.pop_front(); n_checks++;
    if (wb_spurious !== es) begin n_fail++; $display("FAIL sw_spur: got %b, expected %b", wb_spurious, es); end
    #1;
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL sw_rd: got %h, expected %h", rd_data[31:0], ed); end
    eb = exp_busy_q.pop_front(); n_checks++;
    if (rd_busy !== eb) begin n_fail++; $display("FAIL sw_busy: got %b, expected %b", rd_busy, eb); end
    // Retire the outstanding x7 producer.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h66;
    tick();
    idle();
    exp_cnt_q.push_back(6'd0); exp_spur_q.push_back(1'b0);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL sw_cnt_clr: got %0d, expected %0d", pending_cnt, ec); end
    es = exp_spur_q.pop_front(); n_checks++;
    if (wb_spurious !== es) begin n_fail++; $display("FAIL sw_spur_clr: got %b, expected %b", wb_spurious, es); end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      idle(); iss_en = 1'b1; iss_addr = 5'(r);
      tick();
      exp_cnt_q.push_back(6'(r));
      ec = exp_cnt_q.pop_front(); n_checks++;
      if (pending_cnt !== ec) begin n_fail++; $display("FAIL fl_cnt_iss%0d: got %0d, expected %0d", r, pending_cnt, ec); end
    end
    idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA;
    tick();
    idle(); set_rd(9, 4);
    exp_cnt_q.push_back(6'd0); exp_spur_q.push_back(1'b1);
    exp_data_q.push_back(32'hA); exp_busy_q.push_back(2'b00); exp_spur_q.push_back(1'b0);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL fl_cnt: got %0d, expected %0d", pending_cnt, ec); end
    es = exp_spur_q.pop_front(); n_checks++;
    if (wb_spurious !== es) begin n_fail++; $display("FAIL fl_spur: got %b, expected %b", wb_spurious, es); end
    #1;
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL fl_rd9: got %h, expected %h", rd_data[31:0], ed); end
    eb = exp_busy_q.pop_front(); n_checks++;
    if (rd_busy !== eb) begin n_fail++; $display("FAIL fl_busy: got %b, expected %b", rd_busy, eb); end
    tick();
    es = exp_spur_q.pop_front(); n_checks++;
    if (wb_spurious !== es) begin n_fail++; $display("FAIL fl_spur_once: got %b, expected %b", wb_spurious, es); end
  endtask

  // Writes on consecutive cycles with random data; each value is queued at the
  // write and checked when read back afterwards.
  task automatic test_back_to_back();
    logic [XLEN-1:0] v;
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      idle(); wr_en = 1'b1; wr_addr = 5'(16 + i); wr_data = v;
      set_rd(16 + i, 16 + i);
      exp_data_q.push_back(v);
      #1;
      n_checks++;
      if (rd_data[63:32] !== v) begin n_fail++; $display("FAIL b2b_bypass[%0d]: got %h, expected %h", i, rd_data[63:32], v); end
      tick();
      n_checks++;
      if (wb_spurious !== 1'b1) begin n_fail++; $display("FAIL b2b_spur[%0d]: got %b, expected 1", i, wb_spurious); end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      set_rd(16 + i, 0);
      #1;
      ed = exp_data_q.pop_front(); n_checks++;
      if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL b2b_rd[%0d]: got %h, expected %h", i, rd_data[31:0], ed); end
    end
  endtask

  task automatic test_reset_mid();
    idle(); wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h77; iss_en = 1'b1; iss_addr = 5'd12;
    tick();
    idle(); set_rd(10, 12);
    exp_cnt_q.push_back(6'd1); exp_data_q.push_back(32'h77);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL rm_cnt_pre: got %0d, expected %0d", pending_cnt, ec); end
    #1;
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL rm_rd_pre: got %h, expected %h", rd_data[31:0], ed); end
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h99; iss_en = 1'b1; iss_addr = 5'd11; flush = 1'b0;
    tick();
    rst = 1'b0; idle(); set_rd(10, 12);
    exp_cnt_q.push_back(6'd0); exp_spur_q.push_back(1'b0);
    exp_data_q.push_back('0); exp_busy_q.push_back(2'b00); exp_data_q.push_back('0);
    ec = exp_cnt_q.pop_front(); n_checks++;
    if (pending_cnt !== ec) begin n_fail++; $display("FAIL rm_cnt: got %0d, expected %0d", pending_cnt, ec); end
    es = exp_spur_q.pop_front(); n_checks++;
    if (wb_spurious !== es) begin n_fail++; $display("FAIL rm_spur: got %b, expected %b", wb_spurious, es); end
    #1;
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL rm_rd10: got %h, expected %h", rd_data[31:0], ed); end
    eb = exp_busy_q.pop_front(); n_checks++;
    if (rd_busy !== eb) begin n_fail++; $display("FAIL rm_busy: got %b, expected %b", rd_busy, eb); end
    set_rd(5, 0);
    #1;
    ed = exp_data_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== ed) begin n_fail++; $display("FAIL rm_rd5: got %h, expected %h", rd_data[31:0], ed); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; rd_addr = '0; idle();
    test_reset();
    test_bypass();
    test_x0();
    test_set_wins();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
